pong_game_ctrl: RTL

//  Game-flow sequencer for the VGA pong top level. Debounces the start button, counts frames from the
//  VGA raster counters, holds both scores and drives the ball/menu/game-over layer controls.
//  It sits between the raster timing and the ball, menu and score_list layers. It is the only owner of score1/score2.

---
 rtl/pong_game_ctrl.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for the VGA pong top level.
// Debounces the start button, counts frames from the raster counters,
// holds both scores and drives the ball / menu / game-over layer controls.
//
// Pulse interfaces: goal_left, goal_right and ball_reset are single-clock
// strobes with no back-pressure. A strobe is acted on in the clock where it
// is high, or it is dropped if the current state ignores it.
module pong_game_ctrl #(
  parameter int MAX_SCORE    = 5,
  parameter int SCORE_W      = 4,
  parameter int DEBOUNCE_W   = 16,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               btn_start,
  input  logic               goal_left,
  input  logic               goal_right,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_dir,
  output logic               menu_en,
  output logic               over_en,
  output logic               winner
);

  typedef enum logic [2:0] {
    S_MENU  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_POINT = 3'd4,
    S_OVER  = 3'd5
  } state_t;

  localparam logic [8:0]         SERVE_LAST = 9'(SERVE_FRAMES - 1);
  localparam logic [8:0]         POINT_CNT  = 9'(POINT_FRAMES);
  localparam logic [SCORE_W-1:0] MAX_S      = SCORE_W'(MAX_SCORE);
  localparam logic [SCORE_W-1:0] ONE_S      = SCORE_W'(1);

  state_t                  st;
  logic                    btn_meta;
  logic                    btn_sync;
  logic                    btn_db;
  logic                    btn_db_q;
  logic [DEBOUNCE_W-1:0]   db_cnt;
  logic [8:0]              frame_cnt;
  logic                    start_press;
  logic                    frame_tick;
  logic [SCORE_W-1:0]      score1_inc;
  logic [SCORE_W-1:0]      score2_inc;

  // The state register doubles as the externally visible state code.
  assign state       = st;
  assign start_press = btn_db & ~btn_db_q;
  assign frame_tick  = enable && (hcount == 10'd0) && (vcount == 10'd480);
  assign score1_inc  = score1 + ONE_S;
  assign score2_inc  = score2 + ONE_S;

  // Two-flop synchroniser for the asynchronous start button.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      btn_meta <= btn_start;
      btn_sync <= btn_meta;
    end
  end

  // Debounce: the level follows the synchronised input only after it has
  // disagreed for 2**DEBOUNCE_W consecutive clocks; any agreement restarts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_db_q <= btn_db;
      if (btn_sync != btn_db) begin
        if (db_cnt == '1) begin
          btn_db <= btn_sync;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Game FSM with registered layer controls. Every state change clears
  // frame_cnt, which also discards a frame_tick landing on the entry clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st         <= S_MENU;
      frame_cnt  <= '0;
      score1     <= '0;
      score2     <= '0;
      ball_run   <= 1'b0;
      ball_reset <= 1'b0;
      serve_dir  <= 1'b0;
      menu_en    <= 1'b1;
      over_en    <= 1'b0;
      winner     <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      if (frame_tick) frame_cnt <= frame_cnt + 9'd1;
      case (st)
        S_MENU: begin
          score1 <= '0;
          score2 <= '0;
          if (start_press) begin
            st         <= S_SERVE;
            frame_cnt  <= '0;
            ball_reset <= 1'b1;
            serve_dir  <= 1'b0;
            menu_en    <= 1'b0;
            ball_run   <= 1'b0;
          end
        end
        S_SERVE: begin
          if (frame_tick && frame_cnt == SERVE_LAST) begin
            st        <= S_PLAY;
            frame_cnt <= '0;
            ball_run  <= 1'b1;
          end
        end
        S_PLAY: begin
          // goal_left outranks goal_right, and any goal outranks a press.
          if (goal_left) begin
            score2    <= score2_inc;
            serve_dir <= 1'b0;
            ball_run  <= 1'b0;
            frame_cnt <= '0;
            if (score2_inc == MAX_S) begin
              st      <= S_OVER;
              winner  <= 1'b1;
              over_en <= 1'b1;
            end else begin
              st <= S_POINT;
            end
          end else if (goal_right) begin
            score1    <= score1_inc;
            serve_dir <= 1'b1;
            ball_run  <= 1'b0;
            frame_cnt <= '0;
            if (score1_inc == MAX_S) begin
              st      <= S_OVER;
              winner  <= 1'b0;
              over_en <= 1'b1;
            end else begin
              st <= S_POINT;
            end
          end else if (start_press) begin
            st        <= S_PAUSE;
            ball_run  <= 1'b0;
            frame_cnt <= '0;
          end
        end
        S_PAUSE: begin
          if (start_press) begin
            st        <= S_PLAY;
            ball_run  <= 1'b1;
            frame_cnt <= '0;
          end
        end
        S_POINT: begin
          if (frame_cnt == POINT_CNT) begin
            st         <= S_SERVE;
            ball_reset <= 1'b1;
            frame_cnt  <= '0;
          end
        end
        S_OVER: begin
          if (start_press) begin
            st        <= S_MENU;
            score1    <= '0;
            score2    <= '0;
            over_en   <= 1'b0;
            menu_en   <= 1'b1;
            frame_cnt <= '0;
          end
        end
        default: begin
          st        <= S_MENU;
          frame_cnt <= '0;
          ball_run  <= 1'b0;
          menu_en   <= 1'b1;
          over_en   <= 1'b0;
        end
      endcase
    end
  end

endmodule
